// File: rtl/arbitro_pulsos.sv
// Two-channel pulse sequencer: per-channel pending counters, arbitration, one-deep event register.
// Optional build macro ARB_PRIO_FIXA_EN: fixed priority to channel A on ties (default round-robin).
module arbitro_pulsos #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned SEQ_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic             evt_id,
  output logic [SEQ_W-1:0] evt_seq,
  output logic             ovf_a,
  output logic             ovf_b,
  output logic [CNT_W-1:0] pend_a,
  output logic [CNT_W-1:0] pend_b
);

  localparam logic [CNT_W-1:0] PendMax = '1;
  localparam logic [CNT_W-1:0] PendOne = CNT_W'(1);
  localparam logic [SEQ_W-1:0] SeqOne  = SEQ_W'(1);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [SEQ_W-1:0] seq_a_q, seq_a_d, seq_b_q, seq_b_d;
  logic [SEQ_W-1:0] evt_seq_q, evt_seq_d;
  logic             evt_id_q, evt_id_d;
  logic             last_grant_q, last_grant_d;
  logic             ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;

  logic load, grant_b, load_a, load_b, drop_a, drop_b;

  // Arbitration and load decision
  always_comb begin
    load    = 1'b0;
    grant_b = 1'b0;
    if ((state_q == StEmpty) || evt_ready) begin
      load = (pend_a_q != '0) || (pend_b_q != '0);
    end
    if ((pend_a_q != '0) && (pend_b_q != '0)) begin
`ifdef ARB_PRIO_FIXA_EN
      grant_b = 1'b0;
`else
      grant_b = ~last_grant_q;
`endif
    end else begin
      grant_b = (pend_b_q != '0);
    end
    load_a = load & ~grant_b;
    load_b = load & grant_b;
  end

  // Pending counters and sticky overflow flags
  always_comb begin
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    drop_a   = 1'b0;
    drop_b   = 1'b0;
    unique case ({a, load_a})
      2'b10: begin
        if (pend_a_q == PendMax) drop_a = 1'b1;
        else                     pend_a_d = pend_a_q + PendOne;
      end
      2'b01:   pend_a_d = pend_a_q - PendOne;
      default: pend_a_d = pend_a_q;
    endcase
    unique case ({b, load_b})
      2'b10: begin
        if (pend_b_q == PendMax) drop_b = 1'b1;
        else                     pend_b_d = pend_b_q + PendOne;
      end
      2'b01:   pend_b_d = pend_b_q - PendOne;
      default: pend_b_d = pend_b_q;
    endcase
    // A new drop outranks a simultaneous clear
    ovf_a_d = drop_a | (ovf_a_q & ~ovf_clr);
    ovf_b_d = drop_b | (ovf_b_q & ~ovf_clr);
  end

  // Event register, sequence counters and handshake FSM
  always_comb begin
    state_d      = state_q;
    evt_id_d     = evt_id_q;
    evt_seq_d    = evt_seq_q;
    seq_a_d      = seq_a_q;
    seq_b_d      = seq_b_q;
    last_grant_d = last_grant_q;
    if (load) begin
      state_d      = StFull;
      evt_id_d     = grant_b;
      last_grant_d = grant_b;
      if (grant_b) begin
        evt_seq_d = seq_b_q;
        seq_b_d   = seq_b_q + SeqOne;
      end else begin
        evt_seq_d = seq_a_q;
        seq_a_d   = seq_a_q + SeqOne;
      end
    end else if ((state_q == StFull) && evt_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      pend_a_q     <= '0;
      pend_b_q     <= '0;
      seq_a_q      <= '0;
      seq_b_q      <= '0;
      evt_seq_q    <= '0;
      evt_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      ovf_a_q      <= 1'b0;
      ovf_b_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      seq_a_q      <= seq_a_d;
      seq_b_q      <= seq_b_d;
      evt_seq_q    <= evt_seq_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      ovf_a_q      <= ovf_a_d;
      ovf_b_q      <= ovf_b_d;
    end
  end

  assign evt_valid = (state_q == StFull);
  assign evt_id    = evt_id_q;
  assign evt_seq   = evt_seq_q;
  assign ovf_a     = ovf_a_q;
  assign ovf_b     = ovf_b_q;
  assign pend_a    = pend_a_q;
  assign pend_b    = pend_b_q;

endmodule

// File: tb/tb_arbitro_pulsos.sv
// Randomized and directed bench for arbitro_pulsos against an integer-level reference model.
module tb_arbitro_pulsos;

  localparam int CNT_W = 3;
  localparam int SEQ_W = 4;
  localparam int PMAX  = (1 << CNT_W) - 1;
  localparam int SMOD  = 1 << SEQ_W;

  logic             clk, reset, a, b, evt_ready, ovf_clr;
  logic             evt_valid, evt_id, ovf_a, ovf_b;
  logic [SEQ_W-1:0] evt_seq;
  logic [CNT_W-1:0] pend_a, pend_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: plain counts and flags
  int m_pa, m_pb, m_sa, m_sb, m_last, m_valid, m_id, m_seq, m_oa, m_ob;

  arbitro_pulsos #(.CNT_W(CNT_W), .SEQ_W(SEQ_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_seq   (evt_seq),
    .ovf_a     (ovf_a),
    .ovf_b     (ovf_b),
    .pend_a    (pend_a),
    .pend_b    (pend_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pa = 0; m_pb = 0; m_sa = 0; m_sb = 0; m_last = 1;
    m_valid = 0; m_id = 0; m_seq = 0; m_oa = 0; m_ob = 0;
  endtask

  task automatic compare_all();
    check_eq("evt_valid", 32'(evt_valid), 32'(m_valid));
    check_eq("evt_id",    32'(evt_id),    32'(m_id));
    check_eq("evt_seq",   32'(evt_seq),   32'(m_seq));
    check_eq("ovf_a",     32'(ovf_a),     32'(m_oa));
    check_eq("ovf_b",     32'(ovf_b),     32'(m_ob));
    check_eq("pend_a",    32'(pend_a),    32'(m_pa));
    check_eq("pend_b",    32'(pend_b),    32'(m_pb));
  endtask

  // One clock: predict from the model's own state and current inputs, then compare
  task automatic tick();
    int ld, ch, la, lb, pa, pb, oa, ob;
    ld = 0; ch = 0;
    if (reset) begin
      ld = ((m_valid == 0) || evt_ready) && (m_pa > 0 || m_pb > 0);
      if (m_pa > 0 && m_pb > 0) begin
`ifdef ARB_PRIO_FIXA_EN
        ch = 0;
`else
        ch = 1 - m_last;
`endif
      end else begin
        ch = (m_pa > 0) ? 0 : 1;
      end
      la = ld && (ch == 0);
      lb = ld && (ch == 1);
      pa = m_pa + int'(a) - la;
      pb = m_pb + int'(b) - lb;
      oa = ovf_clr ? 0 : m_oa;
      ob = ovf_clr ? 0 : m_ob;
      if (pa > PMAX) begin pa = PMAX; oa = 1; end
      if (pb > PMAX) begin pb = PMAX; ob = 1; end
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      model_reset();
    end else begin
      if (ld) begin
        m_id = ch;
        m_last = ch;
        if (ch == 0) begin m_seq = m_sa; m_sa = (m_sa + 1) % SMOD; end
        else         begin m_seq = m_sb; m_sb = (m_sb + 1) % SMOD; end
        m_valid = 1;
      end else if (evt_ready) begin
        m_valid = 0;
      end
      m_pa = pa; m_pb = pb; m_oa = oa; m_ob = ob;
    end
    compare_all();
  endtask

  task automatic drive(input logic va, input logic vb, input logic vr, input logic vc);
    a = va; b = vb; evt_ready = vr; ovf_clr = vc;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic             hold_id;
    logic [SEQ_W-1:0] hold_seq;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();
    #2;

    // Reset held with toggling strobes: everything stays cleared
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i[0], ~i[0], 1, 0);
      tick();
    end
    reset = 1'b1;
    drive(1, 0, 0, 0);
    tick();
    check_eq("s1_not_valid_same_edge", 32'(evt_valid), 32'd0);
    drive(0, 0, 0, 0);
    tick();
    check_eq("s1_valid", 32'(evt_valid), 32'd1);
    check_eq("s1_id", 32'(evt_id), 32'd0);
    check_eq("s1_seq", 32'(evt_seq), 32'd0);

    // Simultaneous a/b, round-robin alternation
    do_reset();
    for (int r = 0; r < 2; r++) begin
      drive(1, 1, 1, 0);
      tick();
      drive(0, 0, 1, 0);
      tick();
`ifndef ARB_PRIO_FIXA_EN
      check_eq("s2_first_id", 32'(evt_id), 32'd0);
      check_eq("s2_first_seq", 32'(evt_seq), 32'(r));
      tick();
      check_eq("s2_second_id", 32'(evt_id), 32'd1);
      check_eq("s2_second_seq", 32'(evt_seq), 32'(r));
`else
      tick();
`endif
      tick();
    end

    // Fill channel A under backpressure, drop the ninth pulse, then drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    check_eq("s3_pend_full", 32'(pend_a), 32'(PMAX));
    check_eq("s3_ovf", 32'(ovf_a), 32'd1);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("s3_drained", 32'(pend_a), 32'd0);

    // Backpressure stability, clear coincident with a new drop
    drive(0, 0, 0, 1);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 1);
    tick();
    check_eq("s4_set_wins", 32'(ovf_a), 32'd1);
    hold_id = evt_id;
    hold_seq = evt_seq;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("s4_hold_id", 32'(evt_id), 32'(hold_id));
      check_eq("s4_hold_seq", 32'(evt_seq), 32'(hold_seq));
    end

    // Sequence wrap on channel A
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 1, 0);
      tick();
      drive(0, 0, 1, 0);
      tick();
      check_eq("s5_seq", 32'(evt_seq), 32'(i % SMOD));
    end
    tick();

    // Asynchronous reset mid-cycle with an event held and B pending
    do_reset();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    check_eq("s6_pre_pend_b", 32'(pend_b), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    reset = 1'b1;
    drive(0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    tick();
    check_eq("s6_seq_restart", 32'(evt_seq), 32'd0);

    // Continuous a with b: fixed-priority build starves B
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, (i == 0), 1, 0);
      tick();
    end
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
